// File: rtl/traffic_pkg.sv
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared phase encoding, default durations and round-robin pick
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

  typedef enum logic [1:0] {
    ALL_RED = 2'b00,
    GREEN   = 2'b01,
    YELLOW  = 2'b10
  } phase_t;

  localparam int c_def_green_cyc  = 20;
  localparam int c_def_yellow_cyc = 5;
  localparam int c_def_allred_cyc = 2;

  // First requesting index after cur (wrapping modulo n), cur itself last;
  // with no demand at all, fall back to plain rotation cur+1.
  function automatic logic [2:0] next_rr(input logic [7:0] demand,
                                         input logic [2:0] cur,
                                         input int         n);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = (int'(cur) + 1 >= n) ? 3'd0 : cur + 3'd1;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k <= n && !found) begin
        idx = int'(cur) + k;
        if (idx >= n) idx = idx - n;
        if (demand[idx[2:0]]) begin
          pick  = idx[2:0];
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_rr_arbiter.sv
// ============================================================================
//  Module      : traffic_rr_arbiter
//  Description : Combinational round-robin next-approach picker with fallback
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_rr_arbiter
  import traffic_pkg::*;
#(
  parameter  int NUM_DIR = 4,
  localparam int DIR_W   = $clog2(NUM_DIR)
) (
  input  logic [NUM_DIR-1:0] demand,
  input  logic [DIR_W-1:0]   cur_dir,
  output logic [DIR_W-1:0]   next_dir
);

  logic [7:0] w_demand_ext;
  logic [2:0] w_cur_ext;
  logic [2:0] w_pick;

  assign w_demand_ext = 8'(demand);
  assign w_cur_ext    = 3'(cur_dir);
  assign w_pick       = next_rr(w_demand_ext, w_cur_ext, NUM_DIR);
  assign next_dir     = DIR_W'(w_pick);

endmodule

`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
// ============================================================================
//  Module      : traffic_phase_ctrl
//  Description : Round-robin, demand-actuated multi-approach signal controller.
//                Optional emergency preemption: define TRAFFIC_EMERG_PREEMPT_EN
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter  int NUM_DIR    = 4,
  parameter  int GREEN_CYC  = c_def_green_cyc,
  parameter  int YELLOW_CYC = c_def_yellow_cyc,
  parameter  int ALLRED_CYC = c_def_allred_cyc,
  parameter  int CNT_W      = 8,
  localparam int DIR_W      = $clog2(NUM_DIR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_DIR-1:0] demand,
`ifdef TRAFFIC_EMERG_PREEMPT_EN
  input  logic               emerg_req,
  input  logic [DIR_W-1:0]   emerg_dir,
`endif
  output logic [NUM_DIR-1:0] red,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] green,
  output logic [DIR_W-1:0]   active_dir,
  output logic [1:0]         phase,
  output logic               phase_done
);

  phase_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [DIR_W-1:0]   r_active;
  logic [DIR_W-1:0]   r_next;

  phase_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [DIR_W-1:0]   w_active_nxt;
  logic [DIR_W-1:0]   w_next_nxt;
  logic [DIR_W-1:0]   w_pick;
  logic [NUM_DIR-1:0] w_red_nxt;
  logic [NUM_DIR-1:0] w_yellow_nxt;
  logic [NUM_DIR-1:0] w_green_nxt;

  traffic_rr_arbiter #(.NUM_DIR(NUM_DIR)) u_arb (
    .demand   (demand),
    .cur_dir  (r_active),
    .next_dir (w_pick)
  );

`ifdef TRAFFIC_EMERG_PREEMPT_EN
  // Out-of-range emergency targets are ignored so no illegal index is served.
  logic w_emerg;
  assign w_emerg = emerg_req && (int'(emerg_dir) < NUM_DIR);
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt - 1'b1;
    w_active_nxt = r_active;
    w_next_nxt   = r_next;
    case (r_state)
      ALL_RED: begin
        if (r_cnt == '0) begin
          w_state_nxt  = GREEN;
          w_cnt_nxt    = CNT_W'(GREEN_CYC - 1);
          w_active_nxt = r_next;
`ifdef TRAFFIC_EMERG_PREEMPT_EN
          if (w_emerg) w_active_nxt = emerg_dir;
`endif
        end
      end
      GREEN: begin
`ifdef TRAFFIC_EMERG_PREEMPT_EN
        if (w_emerg && emerg_dir != r_active) begin
          w_state_nxt = YELLOW;
          w_cnt_nxt   = CNT_W'(YELLOW_CYC - 1);
          w_next_nxt  = emerg_dir;
        end else if (w_emerg) begin
          // Holding at full count makes release start a fresh green period.
          w_cnt_nxt = CNT_W'(GREEN_CYC - 1);
        end else
`endif
        if (r_cnt == '0) begin
          if (w_pick == r_active) begin
            w_cnt_nxt = CNT_W'(GREEN_CYC - 1);
          end else begin
            w_state_nxt = YELLOW;
            w_cnt_nxt   = CNT_W'(YELLOW_CYC - 1);
            w_next_nxt  = w_pick;
          end
        end
      end
      YELLOW: begin
        if (r_cnt == '0) begin
          w_state_nxt = ALL_RED;
          w_cnt_nxt   = CNT_W'(ALLRED_CYC - 1);
        end
      end
      default: begin
        w_state_nxt = ALL_RED;
        w_cnt_nxt   = CNT_W'(ALLRED_CYC - 1);
      end
    endcase
  end

  always_comb begin
    w_red_nxt    = '1;
    w_yellow_nxt = '0;
    w_green_nxt  = '0;
    if (w_state_nxt == GREEN) begin
      w_red_nxt[w_active_nxt]   = 1'b0;
      w_green_nxt[w_active_nxt] = 1'b1;
    end else if (w_state_nxt == YELLOW) begin
      w_red_nxt[w_active_nxt]    = 1'b0;
      w_yellow_nxt[w_active_nxt] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ALL_RED;
      r_cnt      <= CNT_W'(ALLRED_CYC - 1);
      r_active   <= '0;
      r_next     <= '0;
      red        <= '1;
      yellow     <= '0;
      green      <= '0;
      phase_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_active   <= w_active_nxt;
      r_next     <= w_next_nxt;
      red        <= w_red_nxt;
      yellow     <= w_yellow_nxt;
      green      <= w_green_nxt;
      phase_done <= (w_cnt_nxt == '0);
    end
  end

  assign active_dir = r_active;
  assign phase      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
// ============================================================================
//  Module      : tb_traffic_phase_ctrl
//  Description : Self-checking bench: directed scenarios plus random demand
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_phase_ctrl;

  localparam int N = 4;
  localparam int G = 20;
  localparam int Y = 5;
  localparam int A = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] demand = '0;
  logic [N-1:0] red, yellow, green;
  logic [1:0]   active_dir;
  logic [1:0]   phase;
  logic         phase_done;

  int checks   = 0;
  int failures = 0;

  // Reference: phase id (0 all-red, 1 green, 2 yellow), cycles left, served
  // approach and approach chosen for the next green.
  int m_ph, m_left, m_dir, m_next;

  traffic_phase_ctrl #(
    .NUM_DIR(N), .GREEN_CYC(G), .YELLOW_CYC(Y), .ALLRED_CYC(A), .CNT_W(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .demand     (demand),
    .red        (red),
    .yellow     (yellow),
    .green      (green),
    .active_dir (active_dir),
    .phase      (phase),
    .phase_done (phase_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int pick;
    if (rst) begin
      m_ph = 0; m_left = A; m_dir = 0; m_next = 0;
    end else if (m_left > 1) begin
      m_left--;
    end else begin
      case (m_ph)
        0: begin m_ph = 1; m_left = G; m_dir = m_next; end
        1: begin
          pick = (m_dir + 1) % N;
          for (int k = N; k >= 1; k--)
            if (demand[(m_dir + k) % N]) pick = (m_dir + k) % N;
          if (pick == m_dir) m_left = G;
          else begin m_ph = 2; m_left = Y; m_next = pick; end
        end
        default: begin m_ph = 0; m_left = A; end
      endcase
    end
  endtask

  task automatic check_model();
    logic [N-1:0] er, ey, eg;
    er = '1; ey = '0; eg = '0;
    if (m_ph == 1) begin er[m_dir] = 1'b0; eg[m_dir] = 1'b1; end
    else if (m_ph == 2) begin er[m_dir] = 1'b0; ey[m_dir] = 1'b1; end
    chk("red", red, er);
    chk("yellow", yellow, ey);
    chk("green", green, eg);
    chk("active_dir", active_dir, m_dir);
    chk("phase", phase, m_ph);
    chk("phase_done", phase_done, (m_left == 1));
    chk("one_non_red", ($countones(~red) <= 1), 1);
    chk("grn_yel_overlap", green & yellow, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  initial begin
    int n;

    // Reset and full cycle with all approaches demanding
    rst = 1'b1; demand = 4'b1111; tick();
    rst = 1'b0;
    chk("rst_phase", phase, 2'b00);
    chk("rst_red", red, 4'b1111);
    chk("rst_done", phase_done, 0);
    chk("rst_dir", active_dir, 0);
    tick();
    chk("allred_done", phase_done, 1);
    tick();
    chk("first_green", green, 4'b0001);
    repeat (G - 1) tick();
    chk("green_last", green, 4'b0001);
    chk("green_done", phase_done, 1);
    tick();
    chk("yellow0", yellow, 4'b0001);
    repeat (Y) tick();
    chk("allred_after_y", red, 4'b1111);
    repeat (A) tick();
    chk("second_green", green, 4'b0010);

    // Skipping of idle approaches 1 and 3
    rst = 1'b1; demand = 4'b0101; tick();
    rst = 1'b0;
    repeat (120) begin
      tick();
      chk("skip13", red[1] & red[3], 1);
    end

    // Green extension on a lone demand
    rst = 1'b1; demand = 4'b0001; tick();
    rst = 1'b0;
    repeat (100) begin
      tick();
      chk("no_yellow", yellow, 0);
    end

    // Fixed-time rotation without demand
    rst = 1'b1; demand = 4'b0000; tick();
    rst = 1'b0;
    repeat (120) tick();

    // Reset during yellow of approach 2
    rst = 1'b1; tick();
    rst = 1'b0;
    n = 0;
    while (!(m_ph == 2 && m_dir == 2) && n < 300) begin
      tick();
      n++;
    end
    chk("yellow2", yellow, 4'b0100);
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("abort_red", red, 4'b1111);
    chk("abort_dir", active_dir, 0);
    repeat (A) tick();
    chk("abort_green", green, 4'b0001);

    // Random demand with occasional reset
    rst = 1'b1; tick();
    rst = 1'b0;
    repeat (600) begin
      if ($urandom_range(0, 7) == 0) demand = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
